// File: rtl/tm_input_conditioner_if.sv
`default_nettype none
// ============================================================================
// Module  : tm_input_conditioner_if
// Brief   : Board-side switch/button bundle feeding the TuringMachine core.
// Revision: 1.0 - initial release
// ============================================================================
interface tm_input_conditioner_if #(
  parameter int NUM_BTN = 2,
  parameter int DATA_W  = 4
);
  logic [DATA_W-1:0]  sw_raw;
  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] btn_pulse;
  logic [DATA_W-1:0]  data_out;
  logic [DATA_W-1:0]  sw_sync;

  modport master (
    output sw_raw, btn_raw,
    input  btn_level, btn_pulse, data_out, sw_sync
  );

  modport slave (
    input  sw_raw, btn_raw,
    output btn_level, btn_pulse, data_out, sw_sync
  );
endinterface
`default_nettype wire

// File: rtl/tm_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module  : tm_input_conditioner
// Brief   : Synchronises/debounces buttons, makes press pulses, snapshots
//           switches on each Next press.
// Revision: 1.0 - initial release
// ============================================================================
module tm_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int NUM_BTN         = 2,
  parameter int DATA_W          = 4
) (
  input  logic                  clk100,
  input  logic                  reset_n,
  tm_input_conditioner_if.slave bus
);

  localparam int                c_cnt_w = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);

  logic [DATA_W-1:0]  r_sw_s1;
  logic [DATA_W-1:0]  r_sw_s2;
  logic [DATA_W-1:0]  r_data;
  logic [NUM_BTN-1:0] r_btn_s1;
  logic [NUM_BTN-1:0] r_btn_s2;
  logic [NUM_BTN-1:0] r_level;
  logic [NUM_BTN-1:0] r_pulse;
  logic [NUM_BTN-1:0] w_accept;

  // One stability counter per button; w_accept flags the cycle the level flips.
  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    logic [c_cnt_w-1:0] r_cnt;

    assign w_accept[i] = (r_btn_s2[i] != r_level[i]) && (r_cnt == c_last);

    always_ff @(posedge clk100 or negedge reset_n) begin
      if (!reset_n) begin
        r_cnt <= '0;
      end else if ((r_btn_s2[i] == r_level[i]) || w_accept[i]) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + c_cnt_w'(1);
      end
    end
  end

  always_ff @(posedge clk100 or negedge reset_n) begin
    if (!reset_n) begin
      r_sw_s1  <= '0;
      r_sw_s2  <= '0;
      r_btn_s1 <= '0;
      r_btn_s2 <= '0;
      r_level  <= '0;
      r_pulse  <= '0;
      r_data   <= '0;
    end else begin
      r_sw_s1  <= bus.sw_raw;
      r_sw_s2  <= r_sw_s1;
      r_btn_s1 <= bus.btn_raw;
      r_btn_s2 <= r_btn_s1;
      r_level  <= r_level ^ w_accept;
      // Only accepted rising edges pulse; releases flip the level silently.
      r_pulse  <= w_accept & r_btn_s2;
      if (w_accept[0] && r_btn_s2[0]) begin
        r_data <= r_sw_s2;
      end
    end
  end

  assign bus.btn_level = r_level;
  assign bus.btn_pulse = r_pulse;
  assign bus.data_out  = r_data;
  assign bus.sw_sync   = r_sw_s2;

endmodule
`default_nettype wire

// File: tb/tb_tm_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module  : tb_tm_input_conditioner
// Brief   : Directed vector bench for tm_input_conditioner (DEBOUNCE_CYCLES=4).
// Revision: 1.0 - initial release
// ============================================================================
module tb_tm_input_conditioner;

  logic clk;
  logic reset_n;
  int   n_tests;
  int   n_fail;
  int   p0;
  int   p1;

  typedef struct {
    logic [1:0] btn;
    logic [3:0] sw;
    int         cycles;
    logic [1:0] exp_level;
    int         exp_p0;
    int         exp_p1;
    logic [3:0] exp_data;
    logic [3:0] exp_sync;
  } vec_t;

  vec_t vecs[11];

  tm_input_conditioner_if #(.NUM_BTN(2), .DATA_W(4)) bus ();

  tm_input_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .NUM_BTN        (2),
    .DATA_W         (4)
  ) dut (
    .clk100 (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one edge, sample just after it and tally pulses seen.
  task automatic tick();
    @(posedge clk);
    #1;
    p0 += int'(bus.btn_pulse[0]);
    p1 += int'(bus.btn_pulse[1]);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    p0      = 0;
    p1      = 0;

    vecs[0]  = '{2'b00, 4'hA, 10, 2'b00, 0, 0, 4'hA, 4'hA};
    vecs[1]  = '{2'b01, 4'hA,  3, 2'b00, 0, 0, 4'hA, 4'hA};
    vecs[2]  = '{2'b00, 4'hA,  2, 2'b00, 0, 0, 4'hA, 4'hA};
    vecs[3]  = '{2'b01, 4'hA,  3, 2'b00, 0, 0, 4'hA, 4'hA};
    vecs[4]  = '{2'b00, 4'hA, 10, 2'b00, 0, 0, 4'hA, 4'hA};
    vecs[5]  = '{2'b01, 4'h5, 10, 2'b01, 1, 0, 4'h5, 4'h5};
    vecs[6]  = '{2'b00, 4'h3, 10, 2'b00, 0, 0, 4'h5, 4'h3};
    vecs[7]  = '{2'b01, 4'h3, 10, 2'b01, 1, 0, 4'h3, 4'h3};
    vecs[8]  = '{2'b00, 4'hC, 10, 2'b00, 0, 0, 4'h3, 4'hC};
    vecs[9]  = '{2'b10, 4'hC, 10, 2'b10, 0, 1, 4'h3, 4'hC};
    vecs[10] = '{2'b00, 4'hC, 10, 2'b00, 0, 0, 4'h3, 4'hC};

    // Reset with everything driven high: outputs must stay zero.
    reset_n     = 1'b0;
    bus.btn_raw = 2'b11;
    bus.sw_raw  = 4'hF;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("reset_outputs", {bus.btn_level, bus.btn_pulse, bus.data_out, bus.sw_sync}, 0);
    end
    bus.btn_raw = 2'b00;
    tick();
    reset_n = 1'b1;
    ticks(10);
    check("post_reset_level", bus.btn_level, 2'b00);
    check("post_reset_data", bus.data_out, 4'h0);
    check("post_reset_sync", bus.sw_sync, 4'hF);

    // Clean Next press: level and pulse rise 6 edges after the raw change.
    bus.sw_raw = 4'hA;
    ticks(3);
    bus.btn_raw = 2'b01;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check("next_before_accept", {bus.btn_level, bus.btn_pulse}, 4'b0000);
    end
    tick();
    check("next_level", bus.btn_level, 2'b01);
    check("next_pulse", bus.btn_pulse, 2'b01);
    check("next_data", bus.data_out, 4'hA);
    tick();
    check("next_pulse_width", bus.btn_pulse, 2'b00);
    p0 = 0;
    p1 = 0;
    ticks(50);
    check("next_hold_no_repeat", p0, 0);
    check("next_hold_level", bus.btn_level, 2'b01);

    // Release, bounce rejection, Done-vs-data vectors.
    for (int v = 0; v < 11; v++) begin
      bus.btn_raw = vecs[v].btn;
      bus.sw_raw  = vecs[v].sw;
      p0 = 0;
      p1 = 0;
      ticks(vecs[v].cycles);
      check($sformatf("vec%0d_level", v), bus.btn_level, vecs[v].exp_level);
      check($sformatf("vec%0d_p0", v), p0, vecs[v].exp_p0);
      check($sformatf("vec%0d_p1", v), p1, vecs[v].exp_p1);
      check($sformatf("vec%0d_data", v), bus.data_out, vecs[v].exp_data);
      check($sformatf("vec%0d_sync", v), bus.sw_sync, vecs[v].exp_sync);
    end

    // Simultaneous press: both pulses in one single cycle.
    bus.sw_raw  = 4'h7;
    bus.btn_raw = 2'b11;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check("simul_before", bus.btn_pulse, 2'b00);
    end
    tick();
    check("simul_pulse", bus.btn_pulse, 2'b11);
    check("simul_data", bus.data_out, 4'h7);
    tick();
    check("simul_pulse_width", bus.btn_pulse, 2'b00);
    bus.btn_raw = 2'b00;
    ticks(10);
    check("simul_release", bus.btn_level, 2'b00);

    // Reset mid-count with Next still held.
    bus.btn_raw = 2'b01;
    ticks(3);
    reset_n = 1'b0;
    #1;
    check("midreset_clear", {bus.btn_level, bus.btn_pulse, bus.data_out, bus.sw_sync}, 0);
    tick();
    reset_n = 1'b1;
    p0 = 0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check("midreset_before", {bus.btn_level, bus.btn_pulse}, 4'b0000);
    end
    tick();
    check("midreset_pulse", bus.btn_pulse, 2'b01);
    check("midreset_data", bus.data_out, 4'h7);
    ticks(10);
    check("midreset_one_pulse", p0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tm_input_conditioner.md
Name: tm_input_conditioner

Overview:
- Front-end stage that sits directly upstream of the TuringMachine core.
- Turns raw board slide-switches and push-buttons into clean, clock-domain-safe inputs for the core:
  - synchronised and debounced button levels;
  - single-cycle press pulses (drive Next and Done);
  - a switch snapshot latched on each Next press, so input_data is stable and coherent with the Next pulse.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required before a button level is accepted (10 ms at 100 MHz); legal range >= 1.
- NUM_BTN, 2, number of buttons conditioned; index 0 = Next, index 1 = Done.
- DATA_W, 4, switch data width.

Ports:
- clk100  input  1  100 MHz system clock.
- reset_n  input  1  asynchronous active-low reset.
- sw_raw  input  DATA_W  raw slide-switch levels, asynchronous to clk100.
- btn_raw  input  NUM_BTN  raw button levels, asynchronous, active-high.
- btn_level  output  NUM_BTN  debounced button level.
- btn_pulse  output  NUM_BTN  one-cycle pulse on each debounced rising edge.
- data_out  output  DATA_W  switch snapshot captured on each Next press.
- sw_sync  output  DATA_W  continuously synchronised switch levels, not snapshotted.

Behaviour:
- Reset: asserting reset_n=0 immediately clears all of the following to 0: synchroniser flops, counters, btn_level, btn_pulse, data_out, sw_sync.
- Synchronisation: every sw_raw and btn_raw bit passes through a 2-flop synchroniser. A raw change at edge k is visible on the synchronised signal after edge k+2. sw_sync is the second flop of the switch synchroniser.
- Debounce (per button, independent):
  - Each button has a counter of width $clog2(DEBOUNCE_CYCLES+1).
  - If the synchronised value equals btn_level, the counter is reset to 0.
  - If it differs, the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 while the value still differs, btn_level takes the synchronised value and the counter clears.
  - Result: btn_level changes DEBOUNCE_CYCLES cycles after the synchronised value changes, i.e. 2+DEBOUNCE_CYCLES cycles after the raw change.
  - A glitch shorter than DEBOUNCE_CYCLES cycles restarts the count and causes no level change.
- Pulse:
  - btn_pulse[i] = 1 for exactly one cycle, registered in the same cycle btn_level[i] goes 0->1.
  - There is no pulse on release.
  - Holding a button produces no repeat pulses.
- Snapshot:
  - In the same clock edge that sets btn_pulse[0], data_out loads sw_sync.
  - data_out and btn_pulse[0] are therefore visible together, and the core samples valid data on the pulse cycle.
  - data_out holds its value otherwise; a Done press does not change it.
- Simultaneous events:
  - Both buttons may pulse in the same cycle; both pulses are asserted, with no priority or arbitration (the core resolves).
  - A switch change coinciding with the Next edge is snapshotted with whatever sw_sync holds at that edge.
- Reset mid-operation:
  - Any in-progress count is discarded.
  - If a button is still held after reset_n deasserts, it is treated as a new press: after 2+DEBOUNCE_CYCLES cycles btn_level rises and one pulse fires.
- Degenerate case: DEBOUNCE_CYCLES=1 means the level follows the synchronised value with one cycle of latency.
- No combinational path exists from any input to any output.

Test Plan (DEBOUNCE_CYCLES=4 unless noted):
1. Reset values: hold reset_n=0 with btn_raw=2'b11 and sw_raw=4'hF.
   - Required: every output is 0 throughout reset.
2. Clean Next press: release reset, wait 10 cycles, set sw_raw=4'hA, wait 3 cycles, raise btn_raw[0] at edge k.
   - Required: btn_level[0] and btn_pulse[0] rise after edge k+6.
   - Required: the pulse lasts exactly 1 cycle.
   - Required: data_out=4'hA in the pulse cycle.
   - Required: no further pulse while the button is held 50 cycles.
3. Bounce rejection:
   - Toggle btn_raw[0] as 1 for 3 cycles, 0 for 2, 1 for 3, 0 thereafter. Required: no btn_level change and no pulse.
   - Then hold 1 for 10 cycles. Required: exactly one pulse.
4. Done does not disturb data: set data_out=4'h3 via a Next press, change sw_raw to 4'hC, press btn_raw[1].
   - Required: btn_pulse[1] fires once.
   - Required: data_out stays 4'h3 and sw_sync=4'hC.
5. Simultaneous press: raise btn_raw=2'b11 on the same edge.
   - Required: btn_pulse=2'b11 in the same single cycle.
6. Reset mid-count: hold btn_raw[0]=1 and pulse reset_n low for 1 cycle, 3 cycles into the debounce.
   - Required: outputs clear.
   - Required: exactly one pulse arrives 6 cycles after reset release.
